// File: rtl/connect_return_pkg.sv
// Shared types and helpers for the return-direction elastic chain.
package connect_return_pkg;

  // Per-stage occupancy: EMPTY holds nothing, BUSY holds main, FULL holds main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Width needed to count 0..2*depth held entries.
  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/connect_return_stage.sv
// One 2-entry skid stage of the return chain.
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | nothing held, accepting, not presenting
// BUSY  | main holds the head item, still accepting
// FULL  | main + skid both hold items, input stalled
//
// All handshake outputs decode from state_q only, so there is no
// combinational valid->ready or ready->ready path through a stage.
module connect_return_stage
  import connect_return_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bits
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             out_fire;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_bits  = main_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Next-state and payload steering; main always carries the oldest item.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_bits;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_bits;
        end else if (in_fire) begin
          skid_d  = in_bits;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State register with synchronous reset; payload is left unreset on purpose.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
    main_q <= main_d;
    skid_q <= skid_d;
  end

endmodule

// File: rtl/connect_return_chain.sv
// Elastic return path: DEPTH registered skid stages from inner to outer level.
// Optional feature macro: CONNECT_RETURN_OCC_EN adds the io_occupancy counter port.
module connect_return_chain
  import connect_return_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_rsp_in_valid,
  output logic             io_rsp_in_ready,
  input  logic [WIDTH-1:0] io_rsp_in_bits,
  output logic             io_rsp_out_valid,
  input  logic             io_rsp_out_ready,
  output logic [WIDTH-1:0] io_rsp_out_bits
`ifdef CONNECT_RETURN_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] io_occupancy
`endif
);

  // Link k sits between stage k-1 and stage k; link 0 and link DEPTH are the ports.
  logic [DEPTH:0]   valid_c;
  logic [DEPTH:0]   ready_c;
  logic [WIDTH-1:0] bits_c [DEPTH+1];

  assign valid_c[0]       = io_rsp_in_valid;
  assign bits_c[0]        = io_rsp_in_bits;
  assign io_rsp_in_ready  = ready_c[0];
  assign io_rsp_out_valid = valid_c[DEPTH];
  assign io_rsp_out_bits  = bits_c[DEPTH];
  assign ready_c[DEPTH]   = io_rsp_out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    connect_return_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .in_valid (valid_c[k]),
      .in_ready (ready_c[k]),
      .in_bits  (bits_c[k]),
      .out_valid(valid_c[k+1]),
      .out_ready(ready_c[k+1]),
      .out_bits (bits_c[k+1])
    );
  end

`ifdef CONNECT_RETURN_OCC_EN
  localparam int OW = occ_width(DEPTH);

  logic          in_fire;
  logic          out_fire;
  logic [OW-1:0] occ_q, occ_d;

  assign in_fire      = io_rsp_in_valid && io_rsp_in_ready;
  assign out_fire     = io_rsp_out_valid && io_rsp_out_ready;
  assign io_occupancy = occ_q;

  // Net change of held entries; the handshake keeps it within 0..2*DEPTH.
  always_comb begin
    occ_d = occ_q;
    case ({in_fire, out_fire})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Occupancy register, cleared together with the stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end
`endif

endmodule

// File: tb/tb_connect_return_chain.sv
// Scoreboard bench: one WIDTH=8/DEPTH=2 chain (directed) and one WIDTH=1/DEPTH=1 chain (random).
module tb_connect_return_chain;
  import connect_return_pkg::*;

  localparam int OW0 = occ_width(2);
  localparam int OW1 = occ_width(1);

  logic clk;
  logic reset0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [7:0] in_bits0, out_bits0;
  logic reset1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [0:0] in_bits1, out_bits1;
`ifdef CONNECT_RETURN_OCC_EN
  logic [OW0-1:0] occ0;
  logic [OW1-1:0] occ1;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] q0[$];
  logic [0:0] q1[$];
  int cnt1 = 0;

  connect_return_chain #(.WIDTH(8), .DEPTH(2)) dut0 (
    .clk(clk), .reset(reset0),
    .io_rsp_in_valid(in_valid0), .io_rsp_in_ready(in_ready0), .io_rsp_in_bits(in_bits0),
    .io_rsp_out_valid(out_valid0), .io_rsp_out_ready(out_ready0), .io_rsp_out_bits(out_bits0)
`ifdef CONNECT_RETURN_OCC_EN
    , .io_occupancy(occ0)
`endif
  );

  connect_return_chain #(.WIDTH(1), .DEPTH(1)) dut1 (
    .clk(clk), .reset(reset1),
    .io_rsp_in_valid(in_valid1), .io_rsp_in_ready(in_ready1), .io_rsp_in_bits(in_bits1),
    .io_rsp_out_valid(out_valid1), .io_rsp_out_ready(out_ready1), .io_rsp_out_bits(out_bits1)
`ifdef CONNECT_RETURN_OCC_EN
    , .io_occupancy(occ1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard for dut0: push on in_fire, pop and compare on out_fire.
  always @(negedge clk) begin
    if (reset0) begin
      q0.delete();
    end else begin
`ifdef CONNECT_RETURN_OCC_EN
      check("d0_occ_vs_model", 32'(occ0), 32'(q0.size()));
`endif
      if (out_valid0 && out_ready0) begin
        if (q0.size() == 0) begin
          check("d0_unexpected_out", 32'(out_bits0), 32'hDEAD);
        end else begin
          check("d0_order", 32'(out_bits0), 32'(q0.pop_front()));
        end
      end
      if (in_valid0 && in_ready0) q0.push_back(in_bits0);
    end
  end

  // Scoreboard for dut1 plus a held-count model for ready/valid and bound checks.
  always @(negedge clk) begin
    if (reset1) begin
      q1.delete();
      cnt1 = 0;
    end else begin
      check("d1_ready", 32'(in_ready1), 32'(cnt1 < 2));
      check("d1_valid", 32'(out_valid1), 32'(cnt1 > 0));
`ifdef CONNECT_RETURN_OCC_EN
      check("d1_occ", 32'(occ1), 32'(cnt1));
      check("d1_occ_le2", 32'(occ1 <= 2), 32'd1);
`endif
      if (out_valid1 && out_ready1) begin
        if (q1.size() == 0) begin
          check("d1_unexpected_out", 32'(out_bits1), 32'hDEAD);
        end else begin
          check("d1_order", 32'(out_bits1), 32'(q1.pop_front()));
        end
        cnt1--;
      end
      if (in_valid1 && in_ready1) begin
        q1.push_back(in_bits1);
        cnt1++;
      end
    end
  end

  logic [7:0] drain_exp [4];
  int acc;

  initial begin
    drain_exp[0] = 8'h10; drain_exp[1] = 8'h11; drain_exp[2] = 8'h12; drain_exp[3] = 8'h13;
    reset0 = 1'b1; in_valid0 = 1'b1; in_bits0 = 8'hFF; out_ready0 = 1'b1;
    reset1 = 1'b1; in_valid1 = 1'b0; in_bits1 = 1'b0; out_ready1 = 1'b0;

    // Reset held two cycles with valid asserted
    step(); step();
    sample();
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_in_ready", 32'(in_ready0), 32'd1);
`ifdef CONNECT_RETURN_OCC_EN
    check("rst_occ", 32'(occ0), 32'd0);
`endif
    step(); reset0 = 1'b0; in_valid0 = 1'b0;
    step(); step();
    sample();
    check("rst_nothing_accepted", 32'(out_valid0), 32'd0);
    check("rst_queue_empty", 32'(q0.size()), 32'd0);

    // Streaming, DEPTH=2 latency, no bubble
    step(); in_valid0 = 1'b1; in_bits0 = 8'hA5;
    step(); in_bits0 = 8'h3C;
    step(); in_valid0 = 1'b0;
    sample();
    check("stream_v0", 32'(out_valid0), 32'd1);
    check("stream_a5", 32'(out_bits0), 32'hA5);
    step(); sample();
    check("stream_v1", 32'(out_valid0), 32'd1);
    check("stream_3c", 32'(out_bits0), 32'h3C);
    step(); sample();
    check("stream_idle", 32'(out_valid0), 32'd0);

    // Backpressure: exactly 4 accepted, then drain in order
    step(); out_ready0 = 1'b0; in_valid0 = 1'b1; acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_bits0 = 8'h10 + 8'(acc);
      if (in_ready0) acc++;
      step();
    end
    in_valid0 = 1'b0;
    sample();
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_in_ready_low", 32'(in_ready0), 32'd0);
`ifdef CONNECT_RETURN_OCC_EN
    check("bp_occ4", 32'(occ0), 32'd4);
`endif
    step(); out_ready0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("drain_valid", 32'(out_valid0), 32'd1);
      check("drain_bits", 32'(out_bits0), 32'(drain_exp[i]));
      if (i == 2) check("drain_in_ready_back", 32'(in_ready0), 32'd1);
      step();
    end
    sample();
    check("drain_done", 32'(out_valid0), 32'd0);

    // Simultaneous fire at occupancy 2
    step(); out_ready0 = 1'b0; in_valid0 = 1'b1; in_bits0 = 8'h20;
    step(); in_bits0 = 8'h21;
    step(); in_valid0 = 1'b0;
    sample();
    check("sim_head", 32'(out_bits0), 32'h20);
`ifdef CONNECT_RETURN_OCC_EN
    check("sim_occ_before", 32'(occ0), 32'd2);
`endif
    step(); out_ready0 = 1'b1; in_valid0 = 1'b1; in_bits0 = 8'h22;
    step(); in_valid0 = 1'b0;
    sample();
    check("sim_next", 32'(out_bits0), 32'h21);
    check("sim_ready", 32'(in_ready0), 32'd1);
`ifdef CONNECT_RETURN_OCC_EN
    check("sim_occ_after", 32'(occ0), 32'd2);
`endif
    step(); sample();
    check("sim_last", 32'(out_bits0), 32'h22);
    step(); sample();
    check("sim_empty", 32'(out_valid0), 32'd0);

    // Reset mid-stream with 3 items held
    step(); out_ready0 = 1'b0; in_valid0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_bits0 = 8'h30 + 8'(i);
      step();
    end
    in_valid0 = 1'b0;
    sample();
`ifdef CONNECT_RETURN_OCC_EN
    check("mid_occ3", 32'(occ0), 32'd3);
`endif
    check("mid_held_head", 32'(out_bits0), 32'h30);
    step(); reset0 = 1'b1; in_valid0 = 1'b1; in_bits0 = 8'h77; out_ready0 = 1'b1;
    step(); reset0 = 1'b0; in_valid0 = 1'b0;
    sample();
    check("mid_rst_valid", 32'(out_valid0), 32'd0);
    check("mid_rst_ready", 32'(in_ready0), 32'd1);
`ifdef CONNECT_RETURN_OCC_EN
    check("mid_rst_occ", 32'(occ0), 32'd0);
`endif
    step(); in_valid0 = 1'b1; in_bits0 = 8'h40;
    step(); in_valid0 = 1'b0;
    sample();
    check("mid_lat_early", 32'(out_valid0), 32'd0);
    step(); sample();
    check("mid_lat_valid", 32'(out_valid0), 32'd1);
    check("mid_lat_bits", 32'(out_bits0), 32'h40);
    step(); step(); sample();
    check("d0_queue_drained", 32'(q0.size()), 32'd0);

    // DEPTH=1: fill, then one drain re-raises ready on the next cycle
    step(); reset1 = 1'b0; in_valid1 = 1'b1; in_bits1 = 1'b1;
    step(); in_bits1 = 1'b0;
    step(); in_valid1 = 1'b0;
    sample();
    check("d1_full_ready_low", 32'(in_ready1), 32'd0);
    step(); out_ready1 = 1'b1;
    step(); out_ready1 = 1'b0;
    sample();
    check("d1_ready_after_drain", 32'(in_ready1), 32'd1);
    check("d1_second_item", 32'(out_bits1), 32'd0);

    // DEPTH=1 random traffic
    for (int i = 0; i < 1000; i++) begin
      step();
      in_valid1  = 1'($urandom_range(0, 1));
      in_bits1   = 1'($urandom);
      out_ready1 = 1'($urandom_range(0, 1));
    end
    step(); in_valid1 = 1'b0; out_ready1 = 1'b1;
    repeat (4) step();
    sample();
    check("d1_queue_drained", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
